// File: rtl/wallace_pkg.sv
// rtl/wallace_pkg.sv - shared widths and helpers for the Wallace multiplier datapath
// Purpose: default operand/product widths and the CPA segment size used by the
//          final carry-propagate stage, plus the derived pipeline-depth helper.
// Ports:   none (package).
package wallace_pkg;

  localparam int MULT_N  = 8;
  localparam int PROD_W  = 2 * MULT_N;
  localparam int CPA_SEG = 4;

  // Pipeline depth of the segmented CPA; guards against SEG = 0 so the
  // elaboration check in the top can report the real problem.
  function automatic int cpa_stages(input int w, input int seg);
    return (seg > 0) ? (w / seg) : 1;
  endfunction

endpackage

// File: rtl/wallace_final_cpa_pipe_cpa_segment.sv
// rtl/wallace_final_cpa_pipe_cpa_segment.sv - SEG-bit ripple adder slice built from full-adder cells
// Purpose: combinational building blocks for one CPA pipeline stage.
// Ports (wallace_fa):   a, b, ci -> s, co  single-bit full adder.
// Ports (cpa_segment):  a[SEG], b[SEG], cin -> s[SEG], co  ripple adder.

module wallace_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module cpa_segment
  import wallace_pkg::*;
#(
  parameter int SEG = CPA_SEG
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] s,
  output logic           co
);

  logic [SEG:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < SEG; i++) begin : g_bit
    wallace_fa u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  assign co = c[SEG];

endmodule

// File: rtl/wallace_final_cpa_pipe.sv
// rtl/wallace_final_cpa_pipe.sv - pipelined segmented carry-propagate adder for the Wallace tree
// Purpose: adds the sum and carry rows left by the compressor tree, SEG bits
//          per pipeline stage, with valid/ready flow control.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   input handshake for sum_vec/carry_vec
//   sum_vec, carry_vec    W-bit redundant operands (already weight-aligned)
//   out_valid / out_ready output handshake for result/cout
//   result, cout          (sum_vec + carry_vec) mod 2^W and the 2^W carry
module wallace_final_cpa_pipe
  import wallace_pkg::*;
#(
  parameter int W   = PROD_W,
  parameter int SEG = CPA_SEG
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] sum_vec,
  input  logic [W-1:0] carry_vec,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         cout
);

  localparam int STAGES = cpa_stages(W, SEG);
  // Operand skew registers are only needed between stages.
  localparam int OPS    = (STAGES > 1) ? STAGES - 1 : 1;

  if ((SEG < 1) || ((W % ((SEG < 1) ? 1 : SEG)) != 0)) begin : g_bad_cfg
    $error("wallace_final_cpa_pipe: W must be a positive multiple of SEG");
  end

  logic              adv;
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] c_q;
  logic [W-1:0]      res_q  [STAGES];
  logic [W-1:0]      opa_q  [OPS];
  logic [W-1:0]      opb_q  [OPS];

  logic [W-1:0]      opa_in [STAGES];
  logic [W-1:0]      opb_in [STAGES];
  logic [W-1:0]      res_in [STAGES];
  logic [W-1:0]      res_d  [STAGES];
  logic [STAGES-1:0] cin;
  logic [STAGES-1:0] vin;
  logic [STAGES-1:0] seg_co;
  logic [STAGES-1:0][SEG-1:0] seg_s;

  // One global advance: the whole pipe moves or the whole pipe holds.
  assign adv       = ~valid_q[STAGES-1] | out_ready;
  assign in_ready  = adv;
  assign out_valid = valid_q[STAGES-1];
  assign result    = res_q[STAGES-1];
  assign cout      = c_q[STAGES-1];

  // Operands are kept right-shifted so each stage always adds bits [SEG-1:0];
  // finished slices enter the result at the top and shift down, landing in
  // their true position after the last stage.
  always_comb begin
    opa_in[0] = sum_vec;
    opb_in[0] = carry_vec;
    res_in[0] = '0;
    cin[0]    = 1'b0;
    vin[0]    = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      opa_in[k] = opa_q[k-1];
      opb_in[k] = opb_q[k-1];
      res_in[k] = res_q[k-1];
      cin[k]    = c_q[k-1];
      vin[k]    = valid_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      res_d[k] = (res_in[k] >> SEG) | (W'(seg_s[k]) << (W - SEG));
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    cpa_segment #(.SEG(SEG)) u_seg (
      .a   (opa_in[k][SEG-1:0]),
      .b   (opb_in[k][SEG-1:0]),
      .cin (cin[k]),
      .s   (seg_s[k]),
      .co  (seg_co[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      c_q     <= '0;
      for (int k = 0; k < STAGES; k++) begin
        res_q[k] <= '0;
      end
      for (int k = 0; k < OPS; k++) begin
        opa_q[k] <= '0;
        opb_q[k] <= '0;
      end
    end else if (adv) begin
      valid_q <= vin;
      // The output stage keeps its last result when a bubble arrives.
      for (int k = 0; k < STAGES; k++) begin
        if ((k != STAGES - 1) || vin[k]) begin
          res_q[k] <= res_d[k];
          c_q[k]   <= seg_co[k];
        end
      end
      for (int k = 0; k < STAGES - 1; k++) begin
        opa_q[k] <= opa_in[k] >> SEG;
        opb_q[k] <= opb_in[k] >> SEG;
      end
    end
  end

endmodule
